apb_fifo_slave: RTL

APB slave peripheral that terminates the APB master side of the AXI-Lite to APB bridge. It exposes a word-wide loopback FIFO, a status register, a control register and an ID register on a 16-bit APB address space. It generates PREADY/PSLVERR per access and optionally inserts programmable wait states. It is the default downstream target for bridge bring-up and regression.

---
 rtl/apb_fifo_pkg.sv | 17 +
 rtl/sync_fifo.sv | 39 +++
 rtl/apb_fifo_slave.sv | 117 +++++++++++
 3 files changed

// File: rtl/apb_fifo_pkg.sv
// apb_fifo_pkg: register offsets, STATUS/CTRL bit positions, default ID value and FSM states for apb_fifo_slave
package apb_fifo_pkg;
  localparam logic [15:0] ADDR_DATA   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_CTRL   = 16'h0008;
  localparam logic [15:0] ADDR_ID     = 16'h000C;
  localparam int STAT_EMPTY = 16;
  localparam int STAT_FULL = 17;
  localparam int STAT_OVF = 24;
  localparam int STAT_UDF = 25;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLRERR = 1;
  localparam int CTRL_WAIT_LSB = 4;
  localparam int CTRL_WAIT_MSB = 7;
  localparam logic [31:0] ID_VAL_DEFAULT = 32'h4150_4246;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: 32-bit synchronous FIFO; ports clk_i/rst_i, push_i/pop_i/flush_i, wdata_i, head_o, count_o, full_o, empty_o
module sync_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic push_ok, pop_ok;
  assign push_ok = push_i && !full_o;
  assign pop_ok = pop_i && !empty_o;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk_i)
    if (push_ok) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk_i)
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
endmodule

// File: rtl/apb_fifo_slave.sv
// apb_fifo_slave: APB slave with loopback FIFO, STATUS/CTRL/ID regs; ports PCLK, PRST, PADDR/PSEL/PENABLE/PWRITE/PWDATA in, PRDATA/PREADY/PSLVERR/IRQ out; define APB_FIFO_WAIT_EN for CTRL.WAIT wait states
module apb_fifo_slave
  import apb_fifo_pkg::*;
#(
  parameter int          DEPTH  = 8,
  parameter logic [31:0] ID_VAL = ID_VAL_DEFAULT
) (
  input  logic        PCLK,
  input  logic        PRST,
  input  logic [15:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q;
  logic [31:0] wdata_q, prdata_q, head, status, rdata;
  logic pslverr_q, push_q, pop_q, ctrl_q, ovf_set_q, udf_set_q, ovf_q, udf_q;
  logic [AW:0] count;
  logic full, empty, setup, ready, commit, cnt_zero;
  logic is_data, is_status, is_ctrl, is_id, err;
  logic [3:0] wait_q;
  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(PCLK),
    .rst_i(PRST),
    .push_i(commit && push_q),
    .pop_i(commit && pop_q),
    .flush_i(commit && ctrl_q && wdata_q[CTRL_FLUSH]),
    .wdata_i(wdata_q),
    .head_o(head),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );
  assign setup = state_q == ST_IDLE && PSEL && !PENABLE;
  // Gated by PRST so a transfer hit by reset never completes.
  assign ready = state_q == ST_ACCESS && cnt_zero && PSEL && !PRST;
  assign commit = ready && PENABLE;
  assign PREADY = ready;
  assign PRDATA = ready ? prdata_q : '0;
  assign PSLVERR = ready && pslverr_q;
  assign IRQ = ovf_q || udf_q;
`ifdef APB_FIFO_WAIT_EN
  logic [3:0] cnt_q;
  always_ff @(posedge PCLK)
    if (PRST) begin
      wait_q <= '0;
      cnt_q <= '0;
    end else begin
      if (commit && ctrl_q) wait_q <= wdata_q[CTRL_WAIT_MSB:CTRL_WAIT_LSB];
      if (setup) cnt_q <= wait_q;
      else if (state_q == ST_ACCESS && PSEL && !cnt_zero) cnt_q <= cnt_q - 1'b1;
    end
  assign cnt_zero = cnt_q == '0;
`else
  assign wait_q = '0;
  assign cnt_zero = 1'b1;
`endif
  // Response is decided at the setup edge from the FIFO state seen then.
  always_comb begin
    is_data = PADDR == ADDR_DATA;
    is_status = PADDR == ADDR_STATUS;
    is_ctrl = PADDR == ADDR_CTRL;
    is_id = PADDR == ADDR_ID;
    err = !(is_data || is_status || is_ctrl || is_id) || (PWRITE && (is_status || is_id)) ||
          (is_data && (PWRITE ? full : empty));
    status = '0;
    status[AW:0] = count;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL] = full;
    status[STAT_OVF] = ovf_q;
    status[STAT_UDF] = udf_q;
    rdata = (PWRITE || err) ? '0 : is_data ? head : is_status ? status :
            is_ctrl ? 32'(wait_q) << CTRL_WAIT_LSB : ID_VAL;
  end
  always_ff @(posedge PCLK)
    if (PRST) begin
      state_q <= ST_IDLE;
      wdata_q <= '0;
      prdata_q <= '0;
      pslverr_q <= 1'b0;
      push_q <= 1'b0;
      pop_q <= 1'b0;
      ctrl_q <= 1'b0;
      ovf_set_q <= 1'b0;
      udf_set_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (setup) begin
        state_q <= ST_ACCESS;
        wdata_q <= PWDATA;
        prdata_q <= rdata;
        pslverr_q <= err;
        push_q <= is_data && PWRITE && !full;
        pop_q <= is_data && !PWRITE && !empty;
        ctrl_q <= is_ctrl && PWRITE;
        ovf_set_q <= is_data && PWRITE && full;
        udf_set_q <= is_data && !PWRITE && empty;
      end
    end else if (!PSEL || ready) begin
      state_q <= ST_IDLE;
      if (commit) begin
        if (ovf_set_q) ovf_q <= 1'b1;
        if (udf_set_q) udf_q <= 1'b1;
        if (ctrl_q && wdata_q[CTRL_CLRERR]) begin
          ovf_q <= 1'b0;
          udf_q <= 1'b0;
        end
      end
    end
endmodule
